// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
// Read data is valid in the same cycle as mem_ack_i.
interface mem_access_stage_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i
   );
endinterface

// File: rtl/mem_access_stage.sv
// RV32 MEM stage: drives the data bus for loads/stores, extends load data and registers MEM/WB.
// Holds the upstream pipeline while an access is outstanding; flags misaligned access and timeout.
module mem_access_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                RegWrite_i,
   input  logic                MemReg_i,
   input  logic                MemRead_i,
   input  logic                MemWrite_i,
   input  logic [2:0]          funct3_i,
   input  logic [31:0]         ALUResult_i,
   input  logic [31:0]         MemData_i,
   input  logic [4:0]          rd_addr_i,
   output logic                stall_o,
   mem_access_stage_if.master  bus,
   output logic                RegWrite_o,
   output logic                MemReg_o,
   output logic [4:0]          rd_addr_o,
   output logic [31:0]         ALUResult_o,
   output logic [31:0]         ReadData_o,
   output logic                err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             abort_q;
   logic [31:0]      rdata_q;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       be_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic             access;
   logic             legal;
   logic             start;

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] d);
      logic [15:0] lane;
      lane = 16'(d >> {a, 3'b000});
      case (f3)
         3'b000:  return {{24{lane[7]}}, lane[7:0]};
         3'b100:  return {24'd0, lane[7:0]};
         3'b001:  return {{16{lane[15]}}, lane[15:0]};
         3'b101:  return {16'd0, lane[15:0]};
         default: return d;
      endcase
   endfunction

   always_comb begin
      access = MemRead_i | MemWrite_i;
      case (funct3_i)
         3'b000, 3'b100: legal = 1'b1;
         3'b001, 3'b101: legal = ~ALUResult_i[0];
         3'b010:         legal = (ALUResult_i[1:0] == 2'b00);
         default:        legal = 1'b0;
      endcase
      start = (state_q == S_IDLE) & access & legal;
   end

   // Gated by reset so the upstream pipeline is released the instant reset asserts.
   assign stall_o         = rst_i & (start | (state_q == S_BUSY));
   assign bus.mem_req_o   = (state_q == S_BUSY);
   assign bus.mem_we_o    = we_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_be_o    = be_q;
   assign bus.mem_wdata_o = wdata_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         rdata_q     <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         f3_q        <= '0;
         off_q       <= '0;
         RegWrite_o  <= 1'b0;
         MemReg_o    <= 1'b0;
         rd_addr_o   <= '0;
         ALUResult_o <= '0;
         ReadData_o  <= '0;
         err_o       <= 1'b0;
      end else begin
         err_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  // Both MemRead and MemWrite set is treated as a load.
                  RegWrite_o <= 1'b0;
                  state_q    <= S_BUSY;
                  cnt_q      <= '0;
                  abort_q    <= 1'b0;
                  addr_q     <= {ALUResult_i[31:2], 2'b00};
                  we_q       <= ~MemRead_i;
                  be_q       <= MemRead_i ? 4'b1111 : store_be(funct3_i, ALUResult_i[1:0]);
                  wdata_q    <= store_wdata(funct3_i, MemData_i);
                  f3_q       <= funct3_i;
                  off_q      <= ALUResult_i[1:0];
               end else begin
                  RegWrite_o  <= RegWrite_i & ~access;
                  MemReg_o    <= MemReg_i;
                  rd_addr_o   <= rd_addr_i;
                  ALUResult_o <= ALUResult_i;
                  ReadData_o  <= '0;
                  err_o       <= access;
               end
            end
            S_BUSY: begin
               RegWrite_o <= 1'b0;
               cnt_q      <= cnt_q + 1'b1;
               if (bus.mem_ack_i) begin
                  rdata_q <= we_q ? 32'd0 : load_ext(f3_q, off_q, bus.mem_rdata_i);
                  state_q <= S_DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  abort_q <= 1'b1;
                  rdata_q <= '0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               RegWrite_o  <= RegWrite_i & ~abort_q;
               MemReg_o    <= MemReg_i;
               rd_addr_o   <= rd_addr_i;
               ALUResult_o <= ALUResult_i;
               ReadData_o  <= rdata_q;
               err_o       <= abort_q;
               abort_q     <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against an arithmetic reference model.
module tb_mem_access_stage;
   localparam int TO = 16;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        RegWrite_i, MemReg_i, MemRead_i, MemWrite_i;
   logic [2:0]  funct3_i;
   logic [31:0] ALUResult_i, MemData_i;
   logic [4:0]  rd_addr_i;
   logic        stall_o, RegWrite_o, MemReg_o, err_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] ALUResult_o, ReadData_o;

   int checks = 0;
   int errors = 0;

   mem_access_stage_if bus();

   mem_access_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .RegWrite_i(RegWrite_i), .MemReg_i(MemReg_i), .MemRead_i(MemRead_i),
      .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .ALUResult_i(ALUResult_i),
      .MemData_i(MemData_i), .rd_addr_i(rd_addr_i), .stall_o(stall_o), .bus(bus),
      .RegWrite_o(RegWrite_o), .MemReg_o(MemReg_o), .rd_addr_o(rd_addr_o),
      .ALUResult_o(ALUResult_o), .ReadData_o(ReadData_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: sizes in bytes, masks and extension computed arithmetically.
   function automatic int m_size(input logic [2:0] f3);
      if (f3[1:0] == 2'd0) return 1;
      if (f3[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'd0, 3'd4: return 1'b1;
         3'd1, 3'd5: return (a % 2) == 0;
         3'd2:       return (a % 4) == 0;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input bit store, input logic [2:0] f3, input logic [31:0] a);
      int sz, off, be;
      if (!store) return 4'hF;
      sz  = m_size(f3);
      off = int'(a % 4);
      be  = ((1 << sz) - 1) << off;
      return 4'(be);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (m_size(f3))
         1:       return (d & 32'hFF) * 32'h0101_0101;
         2:       return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] d);
      longint v;
      int     bits;
      if (m_size(f3) == 4) return d;
      bits = 8 * m_size(f3);
      v = longint'(d) >> (8 * (a % 4));
      v = v % (64'd1 << bits);
      if (!f3[2] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
      return v[31:0];
   endfunction

   task automatic drive(input bit rw, input bit mr, input bit mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        input bit mreg);
      RegWrite_i = rw; MemRead_i = mr; MemWrite_i = mw; funct3_i = f3;
      ALUResult_i = a; MemData_i = d; rd_addr_i = rd; MemReg_i = mreg;
   endtask

   // One non-memory instruction; a stray ack is applied and must be ignored.
   task automatic nop_cycle();
      logic [31:0] a;
      logic [4:0]  rd;
      bit          rw, mreg;
      a = $urandom; rd = 5'($urandom); rw = 1'($urandom); mreg = 1'($urandom);
      drive(rw, 1'b0, 1'b0, 3'($urandom), a, $urandom, rd, mreg);
      bus.mem_ack_i = 1'($urandom); bus.mem_rdata_i = $urandom;
      #1;
      chk("nop_stall", stall_o, 0);
      @(posedge clk_i); #1;
      bus.mem_ack_i = 1'b0;
      chk("nop_regwrite", RegWrite_o, rw);
      chk("nop_memreg", MemReg_o, mreg);
      chk("nop_rd", rd_addr_o, rd);
      chk("nop_alu", ALUResult_o, a);
      chk("nop_readdata", ReadData_o, 0);
      chk("nop_err", err_o, 0);
      chk("nop_req", bus.mem_req_o, 0);
   endtask

   // One memory instruction; ack_at is the BUSY cycle index of the ack, negative = never.
   task automatic access(input bit mr, input bit mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdata, input int ack_at,
                         input bit rw, input logic [4:0] rd, input bit mreg);
      bit store, lg, tmo;
      int nb;
      store = mw && !mr;
      lg    = m_legal(f3, a);
      tmo   = !(ack_at >= 0 && ack_at < TO);
      nb    = tmo ? TO : ack_at + 1;
      drive(rw, mr, mw, f3, a, d, rd, mreg);
      bus.mem_ack_i = 1'b0;
      #1;
      chk("idle_stall", stall_o, lg);
      chk("idle_req", bus.mem_req_o, 0);
      @(posedge clk_i); #1;
      if (!lg) begin
         chk("ill_err", err_o, 1);
         chk("ill_regwrite", RegWrite_o, 0);
         chk("ill_alu", ALUResult_o, a);
         chk("ill_rd", rd_addr_o, rd);
         chk("ill_readdata", ReadData_o, 0);
         chk("ill_req", bus.mem_req_o, 0);
         chk("ill_stall", stall_o, 0);
         return;
      end
      for (int c = 0; c < nb; c++) begin
         chk("busy_req", bus.mem_req_o, 1);
         chk("busy_stall", stall_o, 1);
         if (c == 0 || c == nb - 1) begin
            chk("busy_addr", bus.mem_addr_o, {a[31:2], 2'b00});
            chk("busy_we", bus.mem_we_o, store);
            chk("busy_be", bus.mem_be_o, m_be(store, f3, a));
            if (store) chk("busy_wdata", bus.mem_wdata_o, m_wdata(f3, d));
            chk("busy_bubble", RegWrite_o, 0);
            chk("busy_err", err_o, 0);
         end
         bus.mem_ack_i   = (c == ack_at);
         bus.mem_rdata_i = (c == ack_at) ? rdata : $urandom;
         @(posedge clk_i); #1;
         bus.mem_ack_i = 1'b0;
      end
      chk("done_req", bus.mem_req_o, 0);
      chk("done_stall", stall_o, 0);
      chk("done_bubble", RegWrite_o, 0);
      @(posedge clk_i); #1;
      chk("wb_regwrite", RegWrite_o, rw && !tmo);
      chk("wb_err", err_o, tmo);
      chk("wb_rd", rd_addr_o, rd);
      chk("wb_alu", ALUResult_o, a);
      chk("wb_memreg", MemReg_o, mreg);
      if (!store && !tmo) chk("wb_readdata", ReadData_o, m_load(f3, a, rdata));
   endtask

   initial begin
      drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd3, 1'b1);
      bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
      #2;
      chk("rst_stall", stall_o, 0);
      chk("rst_req", bus.mem_req_o, 0);
      chk("rst_addr", bus.mem_addr_o, 0);
      chk("rst_regwrite", RegWrite_o, 0);
      chk("rst_alu", ALUResult_o, 0);
      chk("rst_readdata", ReadData_o, 0);
      chk("rst_err", err_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;

      access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, 5'd5, 1'b1);
      chk("lw_const", ReadData_o, 32'hDEADBEEF);
      access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 1'b1, 5'd6, 1'b1);
      chk("lb_const", ReadData_o, 32'hFFFF_FF80);
      access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_FFFF, 2, 1'b1, 5'd7, 1'b1);
      chk("lbu_const", ReadData_o, 32'h0000_0080);
      access(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234, 32'h0, 0, 1'b0, 5'd0, 1'b0);
      chk("sh_regwrite", RegWrite_o, 0);
      access(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1'b1, 5'd8, 1'b1);
      nop_cycle();
      access(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 32'h0, -1, 1'b1, 5'd9, 1'b1);
      nop_cycle();
      access(1'b1, 1'b0, 3'd5, 32'h10E, 32'h0, 32'hBEEF_8001, TO - 1, 1'b1, 5'd10, 1'b1);
      chk("late_ack_hu", ReadData_o, 32'h0000_BEEF);
      nop_cycle();

      // Reset while an access is in flight.
      drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 5'd11, 1'b1);
      @(posedge clk_i); #1;
      chk("rstbusy_req_before", bus.mem_req_o, 1);
      rst_i = 1'b0;
      #1;
      chk("rstbusy_req", bus.mem_req_o, 0);
      chk("rstbusy_stall", stall_o, 0);
      chk("rstbusy_regwrite", RegWrite_o, 0);
      chk("rstbusy_memreg", MemReg_o, 0);
      chk("rstbusy_rd", rd_addr_o, 0);
      chk("rstbusy_alu", ALUResult_o, 0);
      chk("rstbusy_readdata", ReadData_o, 0);
      chk("rstbusy_err", err_o, 0);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
      #1 rst_i = 1'b1;
      nop_cycle();

      for (int i = 0; i < 60; i++) begin
         int kind, ack_at;
         kind   = $urandom_range(0, 3);
         ack_at = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
         if (kind == 0) nop_cycle();
         else access(kind != 2, kind >= 2, 3'($urandom), $urandom, $urandom, $urandom,
                     ack_at, 1'($urandom), 5'($urandom), 1'($urandom));
      end
      nop_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end
endmodule
